// File: rtl/mem_pkg.sv
// Shared types and helpers for the MEM-stage data-memory access controller.
package mem_pkg;

  localparam int LANES = 8;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } mem_size_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } mem_state_e;

  function automatic logic [3:0] size_bytes(input mem_size_e size);
    logic [3:0] bytes;
    case (size)
      SZ_B:    bytes = 4'd1;
      SZ_H:    bytes = 4'd2;
      SZ_W:    bytes = 4'd4;
      default: bytes = 4'd8;
    endcase
    return bytes;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Pipeline-side request/response and dmem-side bus of the MEM-stage access controller.
interface mem_access_ctrl_if
  import mem_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) ();

  logic              req_valid;
  logic              req_is_store;
  logic [ADDR_W-1:0] req_addr;
  mem_size_e         req_size;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;

  logic              dmem_req_valid;
  logic              dmem_req_ready;
  logic [ADDR_W-1:0] dmem_addr;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_wdata;
  logic [LANES-1:0]  dmem_wstrb;
  logic              dmem_resp_valid;
  logic [DATA_W-1:0] dmem_resp_rdata;

  logic [DATA_W-1:0] mem_rdata;
  logic              mem_valid;
  logic              misaligned;
  logic              mem_stall;

  // The controller sits on the slave side; pipeline and dmem models drive the master side.
  modport slave (
    input  req_valid, req_is_store, req_addr, req_size, req_wdata,
    input  dmem_req_ready, dmem_resp_valid, dmem_resp_rdata,
    output req_ready,
    output dmem_req_valid, dmem_addr, dmem_we, dmem_wdata, dmem_wstrb,
    output mem_rdata, mem_valid, misaligned, mem_stall
  );

  modport master (
    output req_valid, req_is_store, req_addr, req_size, req_wdata,
    output dmem_req_ready, dmem_resp_valid, dmem_resp_rdata,
    input  req_ready,
    input  dmem_req_valid, dmem_addr, dmem_we, dmem_wdata, dmem_wstrb,
    input  mem_rdata, mem_valid, misaligned, mem_stall
  );

endinterface

// File: rtl/mem_align_shifter.sv
// Byte-lane alignment for one access: strobes, store-data placement, load-data extraction
// and the natural-alignment check, all derived from size and the offset within a doubleword.
module mem_align_shifter
  import mem_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  mem_size_e         i_size,
  input  logic [2:0]        i_offset,
  input  logic              i_isStore,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [LANES-1:0]  o_wstrb,
  output logic [DATA_W-1:0] o_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_misaligned
);

  logic [3:0]       w_bytes;
  logic [5:0]       w_shamt;
  logic [2:0]       w_alignMask;
  logic [LANES-1:0] w_laneMask;

  // Loads never assert strobes so dmem cannot mistake them for partial writes.
  always_comb begin
    w_bytes      = size_bytes(i_size);
    w_shamt      = {i_offset, 3'b000};
    w_alignMask  = 3'(w_bytes - 4'd1);
    w_laneMask   = LANES'((9'd1 << w_bytes) - 9'd1);
    o_misaligned = |(i_offset & w_alignMask);
    o_wstrb      = i_isStore ? LANES'(w_laneMask << i_offset) : '0;
    o_wdata      = i_wdata << w_shamt;
    o_rdata      = i_rdata >> w_shamt;
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: one load/store per transaction, doubleword-aligned
// dmem request, addressed byte returned at bit 0, pipeline stalled while the access is in flight.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic            clk,
  input  logic            reset,
  mem_access_ctrl_if.slave bus
);

  mem_state_e        r_state;
  mem_size_e         r_size;
  logic [2:0]        r_offset;
  logic              r_store;

  logic [ADDR_W-1:0] r_dmemAddr;
  logic [DATA_W-1:0] r_dmemWdata;
  logic [LANES-1:0]  r_dmemWstrb;
  logic              r_dmemWe;
  logic              r_dmemReqValid;

  logic              r_reqReady;
  logic              r_memValid;
  logic              r_misaligned;
  logic              r_memStall;
  logic [DATA_W-1:0] r_memRdata;

  logic              w_idle;
  mem_size_e         w_size;
  logic [2:0]        w_offset;
  logic              w_isStore;
  logic [LANES-1:0]  w_wstrb;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rdata;
  logic              w_misaligned;

  // In IDLE the shifter looks at the incoming op; afterwards it sees the latched one,
  // which is what the response path needs for the read-data shift.
  assign w_idle    = (r_state == IDLE);
  assign w_size    = w_idle ? bus.req_size     : r_size;
  assign w_offset  = w_idle ? bus.req_addr[2:0] : r_offset;
  assign w_isStore = w_idle ? bus.req_is_store : r_store;

  mem_align_shifter #(
    .DATA_W (DATA_W)
  ) u_alignShifter (
    .i_size       (w_size),
    .i_offset     (w_offset),
    .i_isStore    (w_isStore),
    .i_wdata      (bus.req_wdata),
    .i_rdata      (bus.dmem_resp_rdata),
    .o_wstrb      (w_wstrb),
    .o_wdata      (w_wdata),
    .o_rdata      (w_rdata),
    .o_misaligned (w_misaligned)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_size         <= SZ_B;
      r_offset       <= '0;
      r_store        <= 1'b0;
      r_dmemAddr     <= '0;
      r_dmemWdata    <= '0;
      r_dmemWstrb    <= '0;
      r_dmemWe       <= 1'b0;
      r_dmemReqValid <= 1'b0;
      r_reqReady     <= 1'b1;
      r_memValid     <= 1'b0;
      r_misaligned   <= 1'b0;
      r_memStall     <= 1'b0;
      r_memRdata     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_size      <= bus.req_size;
            r_offset    <= bus.req_addr[2:0];
            r_store     <= bus.req_is_store;
            r_dmemAddr  <= {bus.req_addr[ADDR_W-1:3], 3'b000};
            r_dmemWdata <= w_wdata;
            r_dmemWstrb <= w_wstrb;
            r_dmemWe    <= bus.req_is_store;
            r_reqReady  <= 1'b0;
            if (w_misaligned) begin
              r_state      <= ERR;
              r_misaligned <= 1'b1;
            end else begin
              r_state        <= REQ;
              r_dmemReqValid <= 1'b1;
              r_memStall     <= 1'b1;
            end
          end
        end
        REQ: begin
          if (bus.dmem_req_ready) begin
            r_state        <= WAIT;
            r_dmemReqValid <= 1'b0;
          end
        end
        WAIT: begin
          if (bus.dmem_resp_valid) begin
            r_state    <= DONE;
            r_memRdata <= r_store ? '0 : w_rdata;
            r_memValid <= 1'b1;
            r_memStall <= 1'b0;
          end
        end
        DONE: begin
          r_state    <= IDLE;
          r_memValid <= 1'b0;
          r_reqReady <= 1'b1;
        end
        ERR: begin
          r_state      <= IDLE;
          r_misaligned <= 1'b0;
          r_reqReady   <= 1'b1;
        end
        default: begin
          r_state        <= IDLE;
          r_dmemReqValid <= 1'b0;
          r_memValid     <= 1'b0;
          r_misaligned   <= 1'b0;
          r_memStall     <= 1'b0;
          r_reqReady     <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready      = r_reqReady;
  assign bus.dmem_req_valid = r_dmemReqValid;
  assign bus.dmem_addr      = r_dmemAddr;
  assign bus.dmem_we        = r_dmemWe;
  assign bus.dmem_wdata     = r_dmemWdata;
  assign bus.dmem_wstrb     = r_dmemWstrb;
  assign bus.mem_rdata      = r_memRdata;
  assign bus.mem_valid      = r_memValid;
  assign bus.misaligned     = r_misaligned;
  assign bus.mem_stall      = r_memStall;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a table of single transactions plus hand-written
// sequences for backpressure, late responses, spurious responses and reset mid-access.
module tb_mem_access_ctrl;
  import mem_pkg::*;

  typedef struct {
    logic        isStore;
    logic [63:0] addr;
    mem_size_e   size;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        expMis;
    logic [63:0] expDAddr;
    logic [7:0]  expWstrb;
    logic [63:0] expWdata;
    logic [63:0] expRdata;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  vec_t vecs[12];
  vec_t lastVec;

  mem_access_ctrl_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  mem_access_ctrl #(
    .ADDR_W (64),
    .DATA_W (64)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic isStore, input logic [63:0] addr,
                               input mem_size_e size, input logic [63:0] wdata);
    bus.req_valid    = valid;
    bus.req_is_store = isStore;
    bus.req_addr     = addr;
    bus.req_size     = size;
    bus.req_wdata    = wdata;
  endtask

  // Starts and ends on a falling edge with the controller idle; dmem answers at the earliest.
  task automatic runVector(input vec_t v, input int idx);
    checkOutput($sformatf("v%0d_idleReady", idx), 64'(bus.req_ready), 64'd1);
    applyStimulus(1'b1, v.isStore, v.addr, v.size, v.wdata);
    bus.dmem_req_ready  = 1'b1;
    bus.dmem_resp_valid = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (v.expMis) begin
      checkOutput($sformatf("v%0d_misPulse", idx), 64'(bus.misaligned), 64'd1);
      checkOutput($sformatf("v%0d_misNoReq", idx), 64'(bus.dmem_req_valid), 64'd0);
      checkOutput($sformatf("v%0d_misReady", idx), 64'(bus.req_ready), 64'd0);
      checkOutput($sformatf("v%0d_misStall", idx), 64'(bus.mem_stall), 64'd0);
      @(negedge clk);
      checkOutput($sformatf("v%0d_misEnd", idx), 64'(bus.misaligned), 64'd0);
      checkOutput($sformatf("v%0d_misIdle", idx), 64'(bus.req_ready), 64'd1);
      checkOutput($sformatf("v%0d_misNoReq2", idx), 64'(bus.dmem_req_valid), 64'd0);
      checkOutput($sformatf("v%0d_misNoValid", idx), 64'(bus.mem_valid), 64'd0);
    end else begin
      checkOutput($sformatf("v%0d_reqValid", idx), 64'(bus.dmem_req_valid), 64'd1);
      checkOutput($sformatf("v%0d_dmemAddr", idx), bus.dmem_addr, v.expDAddr);
      checkOutput($sformatf("v%0d_we", idx), 64'(bus.dmem_we), 64'(v.isStore));
      checkOutput($sformatf("v%0d_wstrb", idx), 64'(bus.dmem_wstrb), 64'(v.expWstrb));
      checkOutput($sformatf("v%0d_wdata", idx), bus.dmem_wdata, v.expWdata);
      checkOutput($sformatf("v%0d_stallReq", idx), 64'(bus.mem_stall), 64'd1);
      checkOutput($sformatf("v%0d_busyReady", idx), 64'(bus.req_ready), 64'd0);
      @(negedge clk);
      checkOutput($sformatf("v%0d_waitNoReq", idx), 64'(bus.dmem_req_valid), 64'd0);
      checkOutput($sformatf("v%0d_stallWait", idx), 64'(bus.mem_stall), 64'd1);
      bus.dmem_resp_valid = 1'b1;
      bus.dmem_resp_rdata = v.rdata;
      @(negedge clk);
      bus.dmem_resp_valid = 1'b0;
      checkOutput($sformatf("v%0d_memValid", idx), 64'(bus.mem_valid), 64'd1);
      checkOutput($sformatf("v%0d_memRdata", idx), bus.mem_rdata, v.expRdata);
      checkOutput($sformatf("v%0d_stallDone", idx), 64'(bus.mem_stall), 64'd0);
      @(negedge clk);
      checkOutput($sformatf("v%0d_validPulse", idx), 64'(bus.mem_valid), 64'd0);
      checkOutput($sformatf("v%0d_backIdle", idx), 64'(bus.req_ready), 64'd1);
      checkOutput($sformatf("v%0d_rdataHold", idx), bus.mem_rdata, v.expRdata);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //             store addr          size  wdata                  rdata                  mis  dmemAddr       wstrb  dmemWdata              memRdata
    vecs[0]  = '{1'b0, 64'h1000, SZ_D, 64'h0,                 64'h1122334455667788, 1'b0, 64'h1000, 8'h00, 64'h0,                 64'h1122334455667788};
    vecs[1]  = '{1'b0, 64'h1005, SZ_B, 64'h0,                 64'h1122334455667788, 1'b0, 64'h1000, 8'h00, 64'h0,                 64'h0000000000112233};
    vecs[2]  = '{1'b0, 64'h1002, SZ_B, 64'h0,                 64'h1122334455667788, 1'b0, 64'h1000, 8'h00, 64'h0,                 64'h0000112233445566};
    vecs[3]  = '{1'b1, 64'h2006, SZ_H, 64'h000000000000BEEF,  64'hFFFFFFFFFFFFFFFF, 1'b0, 64'h2000, 8'hC0, 64'hBEEF000000000000,  64'h0};
    vecs[4]  = '{1'b0, 64'h3002, SZ_W, 64'h0,                 64'h0,                1'b1, 64'h3000, 8'h00, 64'h0,                 64'h0};
    vecs[5]  = '{1'b0, 64'h3004, SZ_W, 64'h0,                 64'hAABBCCDD11223344, 1'b0, 64'h3000, 8'h00, 64'h0,                 64'h00000000AABBCCDD};
    vecs[6]  = '{1'b1, 64'h4004, SZ_W, 64'h00000000CAFEF00D,  64'h1234567812345678, 1'b0, 64'h4000, 8'hF0, 64'hCAFEF00D00000000,  64'h0};
    vecs[7]  = '{1'b1, 64'h4007, SZ_B, 64'h000000000000005A,  64'h0,                1'b0, 64'h4000, 8'h80, 64'h5A00000000000000,  64'h0};
    vecs[8]  = '{1'b0, 64'h5001, SZ_H, 64'h0,                 64'h0,                1'b1, 64'h5000, 8'h00, 64'h0,                 64'h0};
    vecs[9]  = '{1'b1, 64'h5004, SZ_D, 64'h1111111111111111,  64'h0,                1'b1, 64'h5000, 8'h00, 64'h0,                 64'h0};
    vecs[10] = '{1'b1, 64'h6008, SZ_D, 64'h0123456789ABCDEF,  64'h0,                1'b0, 64'h6008, 8'hFF, 64'h0123456789ABCDEF,  64'h0};
    vecs[11] = '{1'b0, 64'h600E, SZ_H, 64'h0,                 64'h8899AABBCCDDEEFF, 1'b0, 64'h6008, 8'h00, 64'h0,                 64'h0000000000008899};

    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 64'h0, SZ_B, 64'h0);
    bus.dmem_req_ready  = 1'b0;
    bus.dmem_resp_valid = 1'b0;
    bus.dmem_resp_rdata = 64'h0;

    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_reqReady", 64'(bus.req_ready), 64'd1);
    checkOutput("rst_dmemReqValid", 64'(bus.dmem_req_valid), 64'd0);
    checkOutput("rst_dmemAddr", bus.dmem_addr, 64'h0);
    checkOutput("rst_we", 64'(bus.dmem_we), 64'd0);
    checkOutput("rst_wstrb", 64'(bus.dmem_wstrb), 64'd0);
    checkOutput("rst_wdata", bus.dmem_wdata, 64'h0);
    checkOutput("rst_memRdata", bus.mem_rdata, 64'h0);
    checkOutput("rst_memValid", 64'(bus.mem_valid), 64'd0);
    checkOutput("rst_misaligned", 64'(bus.misaligned), 64'd0);
    checkOutput("rst_stall", 64'(bus.mem_stall), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      runVector(vecs[i], i);
    end

    // Backpressure: dmem holds off for three cycles while upstream keeps presenting a new op
    // and dmem fires a stray response; the request must not move.
    applyStimulus(1'b1, 1'b0, 64'h7000, SZ_D, 64'h0);
    bus.dmem_req_ready = 1'b0;
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 64'h7FF8, SZ_D, 64'hFFFFFFFFFFFFFFFF);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("bp%0d_reqValid", i), 64'(bus.dmem_req_valid), 64'd1);
      checkOutput($sformatf("bp%0d_addr", i), bus.dmem_addr, 64'h7000);
      checkOutput($sformatf("bp%0d_we", i), 64'(bus.dmem_we), 64'd0);
      checkOutput($sformatf("bp%0d_wstrb", i), 64'(bus.dmem_wstrb), 64'd0);
      checkOutput($sformatf("bp%0d_stall", i), 64'(bus.mem_stall), 64'd1);
      checkOutput($sformatf("bp%0d_reqReady", i), 64'(bus.req_ready), 64'd0);
      checkOutput($sformatf("bp%0d_memValid", i), 64'(bus.mem_valid), 64'd0);
      bus.dmem_resp_valid = (i == 1);
      bus.dmem_resp_rdata = 64'hDEADBEEFDEADBEEF;
      bus.dmem_req_ready  = (i == 3);
      @(negedge clk);
    end
    applyStimulus(1'b0, 1'b0, 64'h0, SZ_B, 64'h0);
    bus.dmem_req_ready  = 1'b0;
    bus.dmem_resp_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("lw%0d_stall", i), 64'(bus.mem_stall), 64'd1);
      checkOutput($sformatf("lw%0d_noReq", i), 64'(bus.dmem_req_valid), 64'd0);
      checkOutput($sformatf("lw%0d_memValid", i), 64'(bus.mem_valid), 64'd0);
      checkOutput($sformatf("lw%0d_reqReady", i), 64'(bus.req_ready), 64'd0);
      @(negedge clk);
    end
    bus.dmem_resp_valid = 1'b1;
    bus.dmem_resp_rdata = 64'h0F0E0D0C0B0A0908;
    @(negedge clk);
    bus.dmem_resp_valid = 1'b0;
    checkOutput("lw_memValid", 64'(bus.mem_valid), 64'd1);
    checkOutput("lw_memRdata", bus.mem_rdata, 64'h0F0E0D0C0B0A0908);
    @(negedge clk);
    checkOutput("lw_pulseEnd", 64'(bus.mem_valid), 64'd0);
    checkOutput("lw_idle", 64'(bus.req_ready), 64'd1);

    // A response while idle must neither complete anything nor disturb the held read data.
    bus.dmem_resp_valid = 1'b1;
    bus.dmem_resp_rdata = 64'h123456789ABCDEF0;
    @(negedge clk);
    bus.dmem_resp_valid = 1'b0;
    checkOutput("idleResp_memValid", 64'(bus.mem_valid), 64'd0);
    checkOutput("idleResp_hold", bus.mem_rdata, 64'h0F0E0D0C0B0A0908);
    checkOutput("idleResp_ready", 64'(bus.req_ready), 64'd1);
    @(negedge clk);

    // Reset while waiting for the response: everything returns to idle at once.
    applyStimulus(1'b1, 1'b0, 64'h8000, SZ_D, 64'h0);
    bus.dmem_req_ready = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    checkOutput("rw_reqValid", 64'(bus.dmem_req_valid), 64'd1);
    @(negedge clk);
    checkOutput("rw_inWait", 64'(bus.mem_stall), 64'd1);
    reset               = 1'b1;
    bus.dmem_resp_valid = 1'b1;
    bus.dmem_resp_rdata = 64'h5555555555555555;
    #1;
    checkOutput("rw_reqReady", 64'(bus.req_ready), 64'd1);
    checkOutput("rw_noReq", 64'(bus.dmem_req_valid), 64'd0);
    checkOutput("rw_stall", 64'(bus.mem_stall), 64'd0);
    checkOutput("rw_memValid", 64'(bus.mem_valid), 64'd0);
    checkOutput("rw_memRdata", bus.mem_rdata, 64'h0);
    @(negedge clk);
    checkOutput("rw_heldValid", 64'(bus.mem_valid), 64'd0);
    reset               = 1'b0;
    bus.dmem_resp_valid = 1'b0;
    @(negedge clk);
    checkOutput("rw_afterValid", 64'(bus.mem_valid), 64'd0);
    checkOutput("rw_afterReady", 64'(bus.req_ready), 64'd1);

    lastVec = '{1'b0, 64'h8008, SZ_D, 64'h0, 64'h0102030405060708, 1'b0, 64'h8008, 8'h00, 64'h0, 64'h0102030405060708};
    runVector(lastVec, 99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
